imem_loader: RTL and testbench

Boot-time writer for the instruction memory. It takes a byte stream from the UART receiver over a valid/ready handshake and parses a little-endian word-count header. It packs the payload bytes into 32-bit little-endian words and drives the instruction memory's write port (write enable, word address, write data). It holds the core in reset from power-up until a successful load completes.

---
 rtl/imem_loader.sv | 213 +++++++++++++++++++++
 tb/tb_imem_loader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader -- boot-time instruction memory writer.
//
// Receives a byte stream from the UART receiver over a valid/ready handshake.
// The stream starts with a 4-byte little-endian word count N. It is followed
// by N little-endian 32-bit words, which are written to instruction memory
// word addresses 0..N-1. The core is held in reset (cpu_hold) from power-up
// until a load completes successfully.
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require one trailing
// byte after the payload. That byte must equal the 8-bit sum of all payload
// bytes; a match ends in DONE and a mismatch ends in ERR.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   start                one-cycle load request (honoured in IDLE/DONE/ERR)
//   rx_data/rx_valid     byte stream from the UART receiver
//   rx_ready             byte accepted when rx_valid && rx_ready
//   mem_we/addr/wdata    registered instruction memory write port
//                        (mem_addr is a word index)
//   busy                 load in progress (LEN, DATA, CHK)
//   done, error          sticky completion / abort flags
//   cpu_hold             core reset request
module imem_loader #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_hold
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHK  = 3'd3;
`endif
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  logic [2:0]  state_q,     state_d;
  logic [1:0]  byte_cnt_q,  byte_cnt_d;
  logic [31:0] word_cnt_q,  word_cnt_d;
  logic [31:0] len_q,       len_d;
  // Holds the first three bytes of the current word; the fourth byte is
  // taken straight from rx_data when the word is completed.
  logic [23:0] shift_q,     shift_d;
  logic        mem_we_q,    mem_we_d;
  logic [31:0] mem_addr_q,  mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        done_q,      done_d;
  logic        error_q,     error_d;
  logic        cpu_hold_q,  cpu_hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q,      csum_d;
`endif

  logic        accept;
  logic [31:0] word_full;

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign rx_ready = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);
`else
  assign rx_ready = (state_q == S_LEN) || (state_q == S_DATA);
`endif
  assign busy      = rx_ready;
  assign accept    = rx_valid && rx_ready;
  assign word_full = {rx_data, shift_q};

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign error     = error_q;
  assign cpu_hold  = cpu_hold_q;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    word_cnt_d  = word_cnt_q;
    len_d       = len_q;
    shift_d     = shift_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = done_q;
    error_d     = error_q;
    cpu_hold_d  = cpu_hold_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    case (state_q)
      S_LEN: begin
        if (accept) begin
          shift_d    = {rx_data, shift_q[23:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            len_d = word_full;
            if ((word_full == 32'd0) || (word_full > DEPTH_W)) begin
              state_d = S_ERR;
              error_d = 1'b1;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          shift_d    = {rx_data, shift_q[23:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = csum_q + rx_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = word_cnt_q;
            mem_wdata_d = word_full;
            word_cnt_d  = word_cnt_q + 32'd1;
            // Leaving DATA on the last word keeps the index within 0..N-1.
            if (word_cnt_q == len_q - 32'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = S_CHK;
`else
              state_d    = S_DONE;
              done_d     = 1'b1;
              cpu_hold_d = 1'b0;
`endif
            end
          end
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          if (rx_data == csum_q) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
      end
`endif

      // IDLE, DONE, ERR (and any unused encoding) wait for start.
      default: begin
        if (start) begin
          state_d    = S_LEN;
          done_d     = 1'b0;
          error_d    = 1'b0;
          byte_cnt_d = 2'd0;
          word_cnt_d = 32'd0;
          cpu_hold_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = 8'd0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= 2'd0;
      word_cnt_q  <= 32'd0;
      len_q       <= 32'd0;
      shift_q     <= 24'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_hold_q  <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      word_cnt_q  <= word_cnt_d;
      len_q       <= len_d;
      shift_q     <= shift_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      error_q     <= error_d;
      cpu_hold_q  <= cpu_hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. Expected memory writes are pushed
// into a scoreboard queue by a stream-level reference model; a monitor pops
// and compares on every mem_we. Also honours IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst, start, rx_valid, rx_ready, mem_we, busy, done, error, cpu_hold;
  logic [7:0]  rx_data;
  logic [31:0] mem_addr, mem_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];     // {addr, data}
  logic [7:0]  stream_q[$];
  bit          exp_ok;
  int          exp_consumed;
  logic        prev_we = 1'b0;

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      check("we_pulse_width", {31'd0, prev_we}, 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected", mem_addr, mem_wdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("wr_addr", mem_addr, e[63:32]);
        check("wr_data", mem_wdata, e[31:0]);
      end
    end
    prev_we <= mem_we;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) stream_q.push_back(w[8*i +: 8]);
  endfunction

`ifdef IMEM_LOADER_CHECKSUM_EN
  function automatic void push_csum(input bit good);
    logic [7:0] s;
    s = 8'd0;
    for (int i = 4; i < stream_q.size(); i++) s = s + stream_q[i];
    stream_q.push_back(good ? s : (s ^ 8'h5A));
  endfunction
`endif

  // Reference model: interprets the whole byte stream by its format rules.
  function automatic void model();
    logic [31:0] n, w;
    logic [7:0]  sum;
    n = {stream_q[3], stream_q[2], stream_q[1], stream_q[0]};
    if (n == 32'd0 || n > 32'(DEPTH)) begin
      exp_ok = 1'b0;
      exp_consumed = 4;
      return;
    end
    sum = 8'd0;
    for (int k = 0; k < int'(n); k++) begin
      w = {stream_q[4+4*k+3], stream_q[4+4*k+2], stream_q[4+4*k+1], stream_q[4+4*k]};
      exp_q.push_back({32'(k), w});
      for (int b = 0; b < 4; b++) sum = sum + stream_q[4+4*k+b];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_consumed = 4 + 4*int'(n) + 1;
    exp_ok = (stream_q[4+4*int'(n)] == sum);
`else
    exp_consumed = 4 + 4*int'(n);
    exp_ok = 1'b1;
`endif
  endfunction

  // Offers stream_q byte by byte; leaves the caller #1 after the last accept edge.
  task automatic send_stream(input int gmin, input int gmax, input bit noise, output int stalls);
    stalls = 0;
    for (int i = 0; i < stream_q.size(); i++) begin
      int g, w;
      g = $urandom_range(gmax, gmin);
      if (g > 0) begin
        rx_valid = 1'b0;
        for (int j = 0; j < g; j++) begin
          start = noise ? 1'b1 : 1'b0;
          tick();
        end
        start = 1'b0;
      end
      rx_valid = 1'b1;
      rx_data  = stream_q[i];
      w = 0;
      while (!rx_ready && w < 50) begin
        tick();
        w++;
      end
      if (w >= 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_ready_timeout: byte %0d not accepted within 50 cycles", i);
        rx_valid = 1'b0;
        return;
      end
      stalls += w;
      tick();
    end
  endtask

  task automatic run_load(input int gmin, input int gmax, input bit noise, input bit tput);
    int stalls;
    model();
    while (stream_q.size() > exp_consumed) void'(stream_q.pop_back());
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("hold_after_start", {31'd0, cpu_hold}, 32'd1);
    check("done_cleared", {31'd0, done}, 32'd0);
    check("error_cleared", {31'd0, error}, 32'd0);
    send_stream(gmin, gmax, noise, stalls);
    if (tput) check("stall_cycles", 32'(stalls), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("final_we", {31'd0, mem_we}, 32'd0);
`else
    check("final_we", {31'd0, mem_we}, {31'd0, exp_ok});
`endif
    check("done", {31'd0, done}, {31'd0, exp_ok});
    check("error", {31'd0, error}, {31'd0, !exp_ok});
    check("cpu_hold", {31'd0, cpu_hold}, {31'd0, !exp_ok});
    check("busy_end", {31'd0, busy}, 32'd0);
    // rx_valid is still high here: the byte must not be taken.
    tick();
    check("rx_ready_after", {31'd0, rx_ready}, 32'd0);
    rx_valid = 1'b0;
    tick();
    tick();
    check("writes_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    stream_q.delete();
  endtask

  initial begin
    int stalls;
    logic [31:0] n;
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
    tick(); tick();
    rst = 1'b0;
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      rx_valid = i[0];
      rx_data  = 8'hA5;
      tick();
      check("idle_hold", {31'd0, cpu_hold}, 32'd1);
      check("idle_ready", {31'd0, rx_ready}, 32'd0);
      check("idle_we", {31'd0, mem_we}, 32'd0);
      check("idle_done", {31'd0, done}, 32'd0);
      check("idle_error", {31'd0, error}, 32'd0);
    end
    rx_valid = 1'b0;

    // N=2, rx_valid held high
    stream_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef IMEM_LOADER_CHECKSUM_EN
    push_csum(1'b1);
`endif
    run_load(0, 0, 1'b0, 1'b1);

    // Length zero and length above DEPTH
    stream_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
    run_load(0, 0, 1'b0, 1'b0);
    stream_q = '{8'h41, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    run_load(0, 0, 1'b0, 1'b0);

    // Same N=2 stream, rx_valid toggling, start pulses while busy
    stream_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef IMEM_LOADER_CHECKSUM_EN
    push_csum(1'b1);
`endif
    run_load(1, 1, 1'b1, 1'b0);

    // Reset after 6 payload bytes
    stream_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE};
    exp_q.push_back({32'd0, 32'h12345678});
    start = 1'b1;
    tick();
    start = 1'b0;
    send_stream(0, 0, 1'b0, stalls);
    rst = 1'b1;
    rx_valid = 1'b0;
    tick();
    rst = 1'b0;
    check("midrst_hold", {31'd0, cpu_hold}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ready", {31'd0, rx_ready}, 32'd0);
    check("midrst_we", {31'd0, mem_we}, 32'd0);
    repeat (5) tick();
    check("midrst_writes", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    stream_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01};
`ifdef IMEM_LOADER_CHECKSUM_EN
    push_csum(1'b1);
`endif
    run_load(0, 0, 1'b0, 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    stream_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
    run_load(0, 0, 1'b0, 1'b0);
    stream_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    run_load(0, 0, 1'b0, 1'b0);
`endif

    // Full-depth load
    push_word(32'(DEPTH));
    for (int k = 0; k < DEPTH; k++) push_word($urandom);
`ifdef IMEM_LOADER_CHECKSUM_EN
    push_csum(1'b1);
`endif
    run_load(0, 0, 1'b0, 1'b1);

    // Randomized loads
    for (int r = 0; r < 8; r++) begin
      n = 32'($urandom_range(8, 1));
      push_word(n);
      for (int k = 0; k < int'(n); k++) push_word($urandom);
`ifdef IMEM_LOADER_CHECKSUM_EN
      push_csum(1'($urandom_range(1, 0)));
`endif
      run_load(0, 2, 1'($urandom_range(1, 0)), 1'b0);
    end
    for (int r = 0; r < 4; r++) begin
      n = r[0] ? 32'(DEPTH + 1) + ($urandom % 32'd100000) : 32'd0;
      if (r == 2) n = $urandom | 32'h8000_0000;
      push_word(n);
      push_word($urandom);
      run_load(0, 2, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
